// File: rtl/alu_pkg.sv
// +------------------------------------------------------------------------+
// | Module  : alu_pkg                                                      |
// | Brief   : Opcode encodings, default width and control states for ALU.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] OP_NOTA = 4'd0;
  localparam logic [3:0] OP_NOTB = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_LSL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ASL  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_ADD  = 4'd13;
  localparam logic [3:0] OP_SUB  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_booth_mul.sv
// +------------------------------------------------------------------------+
// | Module  : alu_booth_mul                                                |
// | Brief   : Radix-2 Booth signed multiplier, one step per clock.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module alu_booth_mul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               load,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               last_step
);

  localparam int            CW     = $clog2(WIDTH);
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

  logic              r_busy;
  logic [CW-1:0]     r_count;
  logic [WIDTH-1:0]  r_m;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH:0]    r_acc;
  logic              r_qm1;

  logic [WIDTH:0]    w_m_ext;
  logic [WIDTH:0]    w_sum;
  logic [2*WIDTH+1:0] w_cat;

  // Accumulator carries one guard bit so the most negative multiplicand
  // cannot overflow the add/subtract before the arithmetic shift.
  always_comb begin
    w_m_ext = {r_m[WIDTH-1], r_m};
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_acc + w_m_ext;
      2'b10:   w_sum = r_acc - w_m_ext;
      default: w_sum = r_acc;
    endcase
    w_cat = {w_sum[WIDTH], w_sum, r_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_qm1   <= 1'b0;
    end else if (clear) begin
      r_busy  <= 1'b0;
      r_count <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_qm1   <= 1'b0;
    end else if (load) begin
      r_busy  <= 1'b1;
      r_count <= '0;
      r_m     <= multiplicand;
      r_q     <= multiplier;
      r_acc   <= '0;
      r_qm1   <= 1'b0;
    end else if (r_busy) begin
      r_acc   <= w_cat[2*WIDTH+1:WIDTH+1];
      r_q     <= w_cat[WIDTH:1];
      r_qm1   <= w_cat[0];
      if (r_count == C_LAST) begin
        r_busy <= 1'b0;
      end else begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  assign product   = {r_acc[WIDTH-1:0], r_q};
  assign last_step = r_busy && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/alu_alu.sv
// +------------------------------------------------------------------------+
// | Module  : alu_alu                                                      |
// | Brief   : 16-op ALU, single-cycle datapath plus Booth multiply, with   |
// |           start/done handshake.                                        |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module alu_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [3:0]       op_code,
  input  logic [1:0]       shift,
  input  logic [WIDTH-1:0] operand_1,
  input  logic [WIDTH-1:0] operand_2,
  input  logic             op_start,
  input  logic             op_clear,
  output logic [WIDTH-1:0] result_2,
  output logic [WIDTH-1:0] result_1,
  output logic             op_done
);

  alu_state_e         r_state, w_state_nxt;
  logic [WIDTH-1:0]   r_res1, r_res2, w_res1_nxt, w_res2_nxt;
  logic               r_done, w_done_nxt;
  logic               r_sel_mul, w_sel_mul_nxt;
  logic               w_mul_load;
  logic               w_mul_last;
  logic [2*WIDTH-1:0] w_mul_prod;

  logic [WIDTH-1:0]   w_alu1, w_alu2;
  logic [WIDTH:0]     w_add, w_sub;
  logic [2*WIDTH-1:0] w_rol_ext, w_ror_ext;
  logic [WIDTH-1:0]   w_asr;

  always_comb begin
    w_add     = {1'b0, operand_1} + {1'b0, operand_2};
    w_sub     = {1'b0, operand_1} - {1'b0, operand_2};
    w_rol_ext = {operand_1, operand_1} << shift;
    w_ror_ext = {operand_1, operand_1} >> shift;
    w_asr     = $signed(operand_1) >>> shift;
    w_alu2    = '0;
    case (op_code)
      OP_NOTA: w_alu1 = ~operand_1;
      OP_NOTB: w_alu1 = ~operand_2;
      OP_AND:  w_alu1 = operand_1 & operand_2;
      OP_OR:   w_alu1 = operand_1 | operand_2;
      OP_XOR:  w_alu1 = operand_1 ^ operand_2;
      OP_XNOR: w_alu1 = ~(operand_1 ^ operand_2);
      OP_NAND: w_alu1 = ~(operand_1 & operand_2);
      OP_LSL,
      OP_ASL:  w_alu1 = operand_1 << shift;
      OP_LSR:  w_alu1 = operand_1 >> shift;
      OP_ASR:  w_alu1 = w_asr;
      OP_ROL:  w_alu1 = w_rol_ext[2*WIDTH-1:WIDTH];
      OP_ROR:  w_alu1 = w_ror_ext[WIDTH-1:0];
      OP_ADD: begin
        w_alu1 = w_add[WIDTH-1:0];
        w_alu2 = {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
      end
      OP_SUB: begin
        w_alu1 = w_sub[WIDTH-1:0];
        w_alu2 = {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
      end
      default: w_alu1 = '0;
    endcase
  end

  // Clear wins over start; a start while multiplying falls through untouched.
  always_comb begin
    w_state_nxt   = r_state;
    w_res1_nxt    = r_res1;
    w_res2_nxt    = r_res2;
    w_done_nxt    = r_done;
    w_sel_mul_nxt = r_sel_mul;
    w_mul_load    = 1'b0;
    if (op_clear) begin
      w_state_nxt   = ST_IDLE;
      w_res1_nxt    = '0;
      w_res2_nxt    = '0;
      w_done_nxt    = 1'b0;
      w_sel_mul_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (op_start) begin
            if (op_code == OP_MUL) begin
              w_state_nxt   = ST_MUL;
              w_done_nxt    = 1'b0;
              w_sel_mul_nxt = 1'b1;
              w_mul_load    = 1'b1;
            end else begin
              w_state_nxt   = ST_DONE;
              w_done_nxt    = 1'b1;
              w_sel_mul_nxt = 1'b0;
              w_res1_nxt    = w_alu1;
              w_res2_nxt    = w_alu2;
            end
          end
        end
        ST_MUL: begin
          if (w_mul_last) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      r_state   <= ST_IDLE;
      r_res1    <= '0;
      r_res2    <= '0;
      r_done    <= 1'b0;
      r_sel_mul <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_res1    <= w_res1_nxt;
      r_res2    <= w_res2_nxt;
      r_done    <= w_done_nxt;
      r_sel_mul <= w_sel_mul_nxt;
    end
  end

  alu_booth_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk          (clk),
    .rst          (reset_n),
    .clear        (op_clear),
    .load         (w_mul_load),
    .multiplicand (operand_1),
    .multiplier   (operand_2),
    .product      (w_mul_prod),
    .last_step    (w_mul_last)
  );

  // Multiply results are read straight from the multiplier's registers.
  assign result_1 = r_sel_mul ? w_mul_prod[WIDTH-1:0]       : r_res1;
  assign result_2 = r_sel_mul ? w_mul_prod[2*WIDTH-1:WIDTH] : r_res2;
  assign op_done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_alu_alu.sv
// +------------------------------------------------------------------------+
// | Module  : tb_alu_alu                                                   |
// | Brief   : Self-checking bench for alu_alu: vector table, random ops    |
// |           against a reference model, and handshake corner sequences.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_alu_alu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  op_code;
  logic [1:0]  shift;
  logic [31:0] operand_1, operand_2;
  logic        op_start, op_clear;
  logic [31:0] result_2, result_1;
  logic        op_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op_code   (op_code),
    .shift     (shift),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .op_start  (op_start),
    .op_clear  (op_clear),
    .result_2  (result_2),
    .result_1  (result_1),
    .op_done   (op_done)
  );

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e2;
    logic [31:0] e1;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference computed from the operation definitions with plain arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [1:0] s,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r1, r2, pw;
    logic [63:0] p;
    int sa, sb;
    r2 = 32'd0;
    pw = 32'd1 << s;
    case (op)
      4'd0:  r1 = ~a;
      4'd1:  r1 = ~b;
      4'd2:  r1 = a & b;
      4'd3:  r1 = a | b;
      4'd4:  r1 = a ^ b;
      4'd5:  r1 = ~(a ^ b);
      4'd6:  r1 = ~(a & b);
      4'd7, 4'd9: r1 = a * pw;
      4'd8:  r1 = a / pw;
      4'd10: begin
        r1 = a / pw;
        if (a[31]) r1 = r1 | ~(32'hFFFF_FFFF / pw);
      end
      4'd11: begin
        r1 = a;
        for (int k = 0; k < int'(s); k++) r1 = {r1[30:0], r1[31]};
      end
      4'd12: begin
        r1 = a;
        for (int k = 0; k < int'(s); k++) r1 = {r1[0], r1[31:1]};
      end
      4'd13: begin
        p  = {32'd0, a} + {32'd0, b};
        r1 = p[31:0];
        r2 = {31'd0, p[32]};
      end
      4'd14: begin
        r1 = a - b;
        r2 = (a < b) ? 32'd1 : 32'd0;
      end
      default: begin
        sa = a;
        sb = b;
        p  = longint'(sa) * longint'(sb);
        r1 = p[31:0];
        r2 = p[63:32];
      end
    endcase
    return {r2, r1};
  endfunction

  // Called just after a falling edge; returns at a falling edge with results sampled.
  task automatic run_op(input logic [3:0] op, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] r2,
                        output logic [31:0] r1, output logic d);
    op_code   = op;
    shift     = s;
    operand_1 = a;
    operand_2 = b;
    op_start  = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    lat = 0;
    if (op == 4'd15) begin
      chk("mul_done_drops", {63'd0, op_done}, 64'd0);
      while (!op_done && lat < 40) begin
        @(negedge clk);
        lat++;
      end
    end
    r2 = result_2;
    r1 = result_1;
    d  = op_done;
  endtask

  task automatic check_op(input string tag, input logic [3:0] op, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    int lat;
    logic [31:0] r2, r1;
    logic d;
    run_op(op, s, a, b, lat, r2, r1, d);
    chk({tag, "_latency"}, 64'(lat), (op == 4'd15) ? 64'd32 : 64'd0);
    chk({tag, "_done"}, {63'd0, d}, 64'd1);
    chk({tag, "_result"}, {r2, r1}, exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] r2, r1;
    logic d;
    logic [3:0] rop;
    logic [1:0] rs;
    logic [31:0] ra, rb;

    vecs[0]  = '{4'd0,  2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
    vecs[1]  = '{4'd2,  2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF};
    vecs[2]  = '{4'd13, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFFE};
    vecs[3]  = '{4'd14, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
    vecs[4]  = '{4'd8,  2'd2, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h3FFF_FFFF};
    vecs[5]  = '{4'd10, 2'd2, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFF};
    vecs[6]  = '{4'd11, 2'd2, 32'h8000_0001, 32'h0,         32'h0,         32'h0000_0006};
    vecs[7]  = '{4'd12, 2'd2, 32'h8000_0001, 32'h0,         32'h0,         32'h6000_0000};
    vecs[8]  = '{4'd15, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h1};
    vecs[9]  = '{4'd15, 2'd0, 32'd10,        32'hFFFF_FFF6, 32'hFFFF_FFFF, 32'hFFFF_FF9C};
    vecs[10] = '{4'd14, 2'd0, 32'd1,         32'd2,         32'h1,         32'hFFFF_FFFF};
    vecs[11] = '{4'd7,  2'd0, 32'h1234_5678, 32'h0,         32'h0,         32'h1234_5678};
    vecs[12] = '{4'd15, 2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[13] = '{4'd9,  2'd3, 32'hF000_0001, 32'h0,         32'h0,         32'h8000_0008};
    vecs[14] = '{4'd1,  2'd0, 32'h0,         32'h0F0F_0F0F, 32'h0,         32'hF0F0_F0F0};
    vecs[15] = '{4'd6,  2'd0, 32'hFFFF_0000, 32'h0FF0_0FF0, 32'h0,         32'hF00F_FFFF};
    vecs[16] = '{4'd5,  2'd0, 32'hAAAA_AAAA, 32'h5555_5555, 32'h0,         32'h0};
    vecs[17] = '{4'd3,  2'd0, 32'h00FF_0000, 32'h0000_00FF, 32'h0,         32'h00FF_00FF};
    vecs[18] = '{4'd4,  2'd0, 32'h00FF_0000, 32'h0000_00FF, 32'h0,         32'h00FF_00FF};
    vecs[19] = '{4'd13, 2'd0, 32'h7FFF_FFFF, 32'h1,         32'h0,         32'h8000_0000};
    vecs[20] = '{4'd10, 2'd1, 32'h4000_0000, 32'h0,         32'h0,         32'h2000_0000};
    vecs[21] = '{4'd15, 2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001};

    reset_n = 1'b1; op_code = '0; shift = '0; operand_1 = '0; operand_2 = '0;
    op_start = 1'b0; op_clear = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    chk("reset_result", {result_2, result_1}, 64'd0);
    chk("reset_done", {63'd0, op_done}, 64'd0);

    for (int i = 0; i < 22; i++) begin
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].s, vecs[i].a, vecs[i].b,
               {vecs[i].e2, vecs[i].e1});
    end

    // op_done and results hold while idle
    check_op("hold_setup", 4'd3, 2'd0, 32'h1, 32'h2, 64'h3);
    repeat (3) @(negedge clk);
    chk("hold_done", {63'd0, op_done}, 64'd1);
    chk("hold_result", {result_2, result_1}, 64'h3);

    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom_range(0, 15));
      rs  = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      check_op($sformatf("rand%0d_op%0d", i, rop), rop, rs, ra, rb, model(rop, rs, ra, rb));
    end

    // clear mid-multiply
    op_code = 4'd15; operand_1 = 32'd1234; operand_2 = 32'd5678; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (10) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    chk("clr_mid_result", {result_2, result_1}, 64'd0);
    chk("clr_mid_done", {63'd0, op_done}, 64'd0);
    repeat (40) @(negedge clk);
    chk("clr_mid_stays_idle", {63'd0, op_done}, 64'd0);
    check_op("after_clr", 4'd15, 2'd0, 32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1);

    // start while busy is ignored
    op_code = 4'd15; operand_1 = 32'd3; operand_2 = 32'd5; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    op_code = 4'd3; operand_1 = 32'hFFFF_0000; operand_2 = 32'h0000_FFFF; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    chk("busy_start_ignored", {63'd0, op_done}, 64'd0);
    lat = 6;
    while (!op_done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_latency", 64'(lat), 64'd32);
    chk("busy_product", {result_2, result_1}, 64'd15);

    // clear and start together: clear wins, nothing launched
    op_code = 4'd4; operand_1 = 32'h0F0F_0F0F; operand_2 = 32'h0; op_start = 1'b1; op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0; op_clear = 1'b0;
    chk("clr_start_result", {result_2, result_1}, 64'd0);
    chk("clr_start_done", {63'd0, op_done}, 64'd0);
    op_code = 4'd15; op_clear = 1'b1; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0; op_clear = 1'b0;
    repeat (35) @(negedge clk);
    chk("clr_start_mul_not_launched", {63'd0, op_done}, 64'd0);

    // asynchronous reset mid-multiply
    run_op(4'd0, 2'd0, 32'h0, 32'h0, lat, r2, r1, d);
    op_code = 4'd15; operand_1 = 32'd7; operand_2 = 32'd9; op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("async_rst_result", {result_2, result_1}, 64'd0);
    chk("async_rst_done", {63'd0, op_done}, 64'd0);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (40) @(negedge clk);
    chk("rst_mul_aborted", {63'd0, op_done}, 64'd0);
    check_op("after_rst", 4'd13, 2'd0, 32'hFFFF_FFFF, 32'd2, 64'h1_0000_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
